// File: rtl/hamming_code_collector_if.sv
// Interface: hamming_code_collector_if
// Bundles the serial input handshake, the parallel codeword output handshake
// and the abort pulse of the Hamming codeword collector.
//   master : serial bit source / downstream consumer side (testbench, system)
//   slave  : the collector itself
// Signals:
//   in_valid, in_bit  -> serial bit offered to the collector
//   in_ready          <- collector can take a bit this cycle
//   out_valid,
//   out_code          <- complete codeword (CODE_W bits, first bit in MSB)
//   out_ready         -> downstream takes out_code this cycle
//   abort             <- one-cycle pulse, partial frame discarded
interface hamming_code_collector_if #(
    parameter int IP_BIT = 5
);
    localparam int CODE_W = IP_BIT + 4;

    logic              in_valid;
    logic              in_bit;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [CODE_W-1:0] out_code;
    logic              abort;

    modport master (
        output in_valid, in_bit, out_ready,
        input  in_ready, out_valid, out_code, abort
    );

    modport slave (
        input  in_valid, in_bit, out_ready,
        output in_ready, out_valid, out_code, abort
    );
endinterface

// File: rtl/hamming_code_collector.sv
// Module: hamming_code_collector
// Serial-to-parallel front end for the Hamming decoder. Shifts IP_BIT+4
// codeword bits in MSB first, then moves the word into a one-entry holding
// register that is presented on out_code with a valid/ready handshake.
// When a second word completes while the holding register is still
// occupied, the word waits in the shift register and in_ready drops until
// the holding register drains.
// Ports:
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of hamming_code_collector_if
//          (in_valid/in_bit/in_ready, out_valid/out_code/out_ready, abort)
module hamming_code_collector #(
    parameter int IP_BIT = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    hamming_code_collector_if.slave  bus
);
    localparam int CODE_W = IP_BIT + 4;
    localparam int CNT_W  = $clog2(CODE_W + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COLLECT   = 2'd1,
        FULL_WAIT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CODE_W-1:0] shift_q, shift_d;
    logic [CODE_W-1:0] hold_q, hold_d;
    logic              ov_q, ov_d;
    logic              abort_q, abort_d;

    logic              in_ready;
    logic              accept;
    logic              drain;
    logic [CODE_W-1:0] shifted;

    // Only a completed word parked in the shift register blocks the source.
    assign in_ready = (state_q != FULL_WAIT);
    assign accept   = bus.in_valid && in_ready;
    assign drain    = ov_q && bus.out_ready;
    assign shifted  = {shift_q[CODE_W-2:0], bus.in_bit};

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = ov_q;
    assign bus.out_code  = hold_q;
    assign bus.abort     = abort_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            hold_q  <= '0;
            ov_q    <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            hold_q  <= hold_d;
            ov_q    <= ov_d;
            abort_q <= abort_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        hold_d  = hold_q;
        // A transfer empties the holding register unless a load below refills it.
        ov_d    = ov_q && !bus.out_ready;
        abort_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d = shifted;
                    cnt_d   = CNT_W'(1);
                    state_d = COLLECT;
                end
            end

            COLLECT: begin
                if (accept) begin
                    shift_d = shifted;
                    if (cnt_q == CNT_W'(CODE_W - 1)) begin
                        cnt_d = '0;
                        // Holding register free now or freed this cycle: load
                        // straight from the incoming bit, no bubble on out_valid.
                        if (!ov_q || drain) begin
                            hold_d  = shifted;
                            ov_d    = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = FULL_WAIT;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    // Mid-frame gap: drop the partial word. Holding register
                    // and any concurrent out transfer are unaffected.
                    cnt_d   = '0;
                    abort_d = 1'b1;
                    state_d = IDLE;
                end
            end

            FULL_WAIT: begin
                if (drain) begin
                    hold_d  = shift_q;
                    ov_d    = 1'b1;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_hamming_code_collector.sv
// Testbench for hamming_code_collector (IP_BIT=5, CODE_W=9).
// A transaction-level model (bit queue, holding queue, parked-word queue)
// predicts in_ready/out_valid/out_code/abort; a negedge process compares
// the DUT against it every cycle. Directed scenarios add literal checks.
module tb_hamming_code_collector;
    localparam int IP_BIT = 5;
    localparam int CODE_W = IP_BIT + 4;

    logic clk;
    logic rst_n;

    hamming_code_collector_if #(.IP_BIT(IP_BIT)) ifc();

    hamming_code_collector #(.IP_BIT(IP_BIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_rdy_low = 0;
    int n_abort   = 0;
    bit rand_or   = 0;

    // model state
    bit                m_bits[$];
    logic [CODE_W-1:0] m_held[$];
    logic [CODE_W-1:0] m_pend[$];
    bit                m_abort;

    // observed transfers
    logic [CODE_W-1:0] got[$];
    int                got_cyc[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: word-level bookkeeping of what the collector holds.
    always @(posedge clk or negedge rst_n) begin : model
        bit xfer, acc;
        logic [CODE_W-1:0] w;
        if (!rst_n) begin
            m_bits.delete();
            m_held.delete();
            m_pend.delete();
            m_abort = 0;
        end else begin
            xfer    = (m_held.size() > 0) && ifc.out_ready;
            acc     = ifc.in_valid && (m_pend.size() == 0);
            m_abort = 0;
            if (m_pend.size() > 0) begin
                if (xfer) begin
                    void'(m_held.pop_front());
                    m_held.push_back(m_pend.pop_front());
                end
            end else begin
                if (xfer) void'(m_held.pop_front());
                if (acc) begin
                    m_bits.push_back(ifc.in_bit);
                    if (m_bits.size() == CODE_W) begin
                        w = '0;
                        foreach (m_bits[i]) w = {w[CODE_W-2:0], m_bits[i]};
                        m_bits.delete();
                        if (m_held.size() == 0) m_held.push_back(w);
                        else                    m_pend.push_back(w);
                    end
                end else if (m_bits.size() > 0) begin
                    m_bits.delete();
                    m_abort = 1;
                end
            end
        end
    end

    // Per-cycle compare and transfer monitor.
    always @(negedge clk) begin
        cyc++;
        check("in_ready",  {31'd0, ifc.in_ready},  {31'd0, m_pend.size() == 0});
        check("out_valid", {31'd0, ifc.out_valid}, {31'd0, m_held.size() > 0});
        check("abort",     {31'd0, ifc.abort},     {31'd0, m_abort});
        if (m_held.size() > 0) check("out_code", 32'(ifc.out_code), 32'(m_held[0]));
        if (ifc.in_ready === 1'b0) n_rdy_low++;
        if (ifc.abort === 1'b1)    n_abort++;
        if (ifc.out_valid && ifc.out_ready) begin
            got.push_back(ifc.out_code);
            got_cyc.push_back(cyc);
        end
    end

    always @(posedge clk) begin
        if (rand_or) begin
            #1;
            ifc.out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Hamming decode: first received bit is position 1; parity at 1,2,4,8.
    function automatic logic [IP_BIT-1:0] decode(input logic [CODE_W-1:0] c);
        logic [CODE_W:1] p;
        int syn;
        for (int k = 1; k <= CODE_W; k++) p[k] = c[CODE_W-k];
        syn = 0;
        for (int k = 1; k <= CODE_W; k++) if (p[k]) syn = syn ^ k;
        if (syn >= 1 && syn <= CODE_W) p[syn] = ~p[syn];
        return {p[3], p[5], p[6], p[7], p[9]};
    endfunction

    task automatic send_bit(input logic b);
        bit ok;
        int n;
        ifc.in_valid = 1'b1;
        ifc.in_bit   = b;
        n = 0;
        do begin
            @(negedge clk);
            ok = (m_pend.size() == 0);
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 300);
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_bit: bit not accepted within %0d cycles", n);
        end
    endtask

    task automatic send_word(input logic [CODE_W-1:0] w, input int nbits);
        for (int i = CODE_W - 1; i >= CODE_W - nbits; i--) send_bit(w[i]);
    endtask

    task automatic idle(input int n);
        ifc.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : stim
        int a0, r0, nfull;
        logic [CODE_W-1:0] w;
        ifc.in_valid  = 1'b0;
        ifc.in_bit    = 1'b0;
        ifc.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst in_ready",  {31'd0, ifc.in_ready},  32'd1);
        check("rst out_valid", {31'd0, ifc.out_valid}, 32'd0);
        check("rst out_code",  32'(ifc.out_code),      32'd0);
        check("rst abort",     {31'd0, ifc.abort},     32'd0);
        rst_n = 1'b1;
        idle(2);

        // 1: single frame, 1-cycle latency, single-cycle valid
        ifc.out_ready = 1'b1;
        send_word(9'h169, CODE_W);
        ifc.in_valid = 1'b0;
        check("t1 out_valid", {31'd0, ifc.out_valid}, 32'd1);
        check("t1 out_code",  32'(ifc.out_code),      32'h169);
        idle(1);
        check("t1 valid drop", {31'd0, ifc.out_valid}, 32'd0);

        // 2: back-to-back frames
        got.delete(); got_cyc.delete();
        r0 = n_rdy_low;
        send_word(9'h169, CODE_W);
        send_word(9'h0A5, CODE_W);
        idle(3);
        check("t2 count", got.size(), 2);
        if (got.size() == 2) begin
            check("t2 word0", 32'(got[0]), 32'h169);
            check("t2 word1", 32'(got[1]), 32'h0A5);
            check("t2 spacing", got_cyc[1] - got_cyc[0], 9);
        end
        check("t2 in_ready low", n_rdy_low - r0, 0);

        // 3: backpressure
        got.delete(); got_cyc.delete();
        ifc.out_ready = 1'b0;
        send_word(9'h169, CODE_W);
        send_word(9'h0A5, CODE_W);
        ifc.in_valid = 1'b0;
        check("t3 in_ready stall", {31'd0, ifc.in_ready}, 32'd0);
        idle(3);
        ifc.out_ready = 1'b1;
        idle(1);
        check("t3 in_ready resume", {31'd0, ifc.in_ready}, 32'd1);
        check("t3 second word",     32'(ifc.out_code),     32'h0A5);
        idle(2);
        check("t3 count", got.size(), 2);
        if (got.size() == 2) begin
            check("t3 word0", 32'(got[0]), 32'h169);
            check("t3 word1", 32'(got[1]), 32'h0A5);
            check("t3 consecutive", got_cyc[1] - got_cyc[0], 1);
        end

        // 4: abort after 4 bits
        got.delete(); got_cyc.delete();
        send_word(9'h150, 4);
        idle(1);
        check("t4 abort pulse", {31'd0, ifc.abort},     32'd1);
        check("t4 no valid",    {31'd0, ifc.out_valid}, 32'd0);
        idle(1);
        check("t4 abort end",   {31'd0, ifc.abort},     32'd0);
        send_word(9'h1FF, CODE_W);
        idle(2);
        check("t4 count", got.size(), 1);
        if (got.size() == 1) check("t4 word", 32'(got[0]), 32'h1FF);

        // 5: reset mid-frame
        got.delete(); got_cyc.delete();
        send_word(9'h1AB, 5);
        #2 rst_n = 1'b0;
        #1;
        check("t5 in_ready",  {31'd0, ifc.in_ready},  32'd1);
        check("t5 out_valid", {31'd0, ifc.out_valid}, 32'd0);
        check("t5 out_code",  32'(ifc.out_code),      32'd0);
        check("t5 abort",     {31'd0, ifc.abort},     32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        a0 = n_abort;
        ifc.in_valid = 1'b0;
        idle(1);
        send_word(9'h001, CODE_W);
        idle(2);
        check("t5 count", got.size(), 1);
        if (got.size() == 1) check("t5 word", 32'(got[0]), 32'h001);
        check("t5 no abort", n_abort - a0, 0);

        // 6: decoder hookup, 9'h169 carries an error at position 9
        got.delete(); got_cyc.delete();
        send_word(9'h169, CODE_W);
        idle(2);
        check("t6 count", got.size(), 1);
        if (got.size() == 1) check("t6 decoded", 32'(decode(got[0])), 32'h14);

        // random traffic with random backpressure and aborts
        got.delete(); got_cyc.delete();
        nfull = 0;
        rand_or = 1;
        for (int k = 0; k < 60; k++) begin
            w = CODE_W'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                send_word(w, $urandom_range(1, CODE_W - 1));
                idle(1);
            end else begin
                send_word(w, CODE_W);
                nfull++;
                if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            end
        end
        ifc.in_valid = 1'b0;
        rand_or = 0;
        #2 ifc.out_ready = 1'b1;
        idle(6);
        check("rand delivered", got.size(), nfull);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
